// File: rtl/dm_sync.sv
// dm_sync: single-port word RAM with byte/half/word access,
// load extension, alignment faults and a req/ready handshake.
module dm_sync #(
  parameter int DEPTH_LOG2  = 11,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req,
  input  logic        We,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] Din,
  output logic        Ready,
  output logic [31:0] Dout,
  output logic        Err
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2 + 2;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       latch;
  logic       fire;

  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   din_q;

  logic          acc_we;
  logic [1:0]    acc_size;
  logic          acc_uns;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_din;

  logic [DEPTH_LOG2-1:0] idx;
  logic        fault;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rword;
  logic [31:0] bsh;
  logic [15:0] hsel;
  logic [31:0] ldata;
  logic        wr_en;

  logic [31:0] mem [WORDS] = '{default: '0};

  logic unused_bits;
  assign unused_bits = ^Addr[31:AW];

  // In IDLE the access (zero wait) uses live inputs, otherwise the latch
  wire live = (state == S_IDLE);
  assign acc_we   = live ? We            : we_q;
  assign acc_size = live ? Size          : size_q;
  assign acc_uns  = live ? Unsigned      : uns_q;
  assign acc_addr = live ? Addr[AW-1:0]  : addr_q;
  assign acc_din  = live ? Din           : din_q;

  assign idx   = acc_addr[AW-1:2];
  assign rword = mem[idx];

  // Next-state: latch on Req in IDLE, count down in WAIT
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    latch    = 1'b0;
    fire     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Req) begin
          latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            fire = 1'b1;
          end else begin
            cnt_nx   = 4'(WAIT_CYCLES - 1);
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          fire     = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
    endcase
  end

  // Alignment / reserved-size fault detection
  always_comb begin
    fault = 1'b0;
    unique case (acc_size)
      2'b00: fault = (acc_addr[1:0] != 2'b00);
      2'b01: fault = 1'b0;
      2'b10: fault = acc_addr[0];
      2'b11: fault = 1'b1;
    endcase
  end

  // Store lane enables and lane-replicated write data
  always_comb begin
    be    = 4'b1111;
    wdata = acc_din;
    unique case (acc_size)
      2'b01: begin
        be    = 4'b0001 << acc_addr[1:0];
        wdata = {4{acc_din[7:0]}};
      end
      2'b10: begin
        be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{acc_din[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = acc_din;
      end
    endcase
  end

  // Load lane select and sign/zero extension
  always_comb begin
    bsh   = rword >> {acc_addr[1:0], 3'b000};
    hsel  = acc_addr[1] ? rword[31:16] : rword[15:0];
    ldata = rword;
    unique case (acc_size)
      2'b01:   ldata = {{24{~acc_uns & bsh[7]}}, bsh[7:0]};
      2'b10:   ldata = {{16{~acc_uns & hsel[15]}}, hsel};
      default: ldata = rword;
    endcase
  end

  assign wr_en = Rst_n & fire & acc_we & ~fault;

  // State, counter and request latch
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      we_q   <= 1'b0;
      size_q <= 2'b00;
      uns_q  <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (latch) begin
        we_q   <= We;
        size_q <= Size;
        uns_q  <= Unsigned;
        addr_q <= Addr[AW-1:0];
        din_q  <= Din;
      end
    end
  end

  // RAM lane writes; contents survive reset
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered completion pulse, fault flag and load data
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Ready <= 1'b0;
      Err   <= 1'b0;
      Dout  <= '0;
    end else begin
      Ready <= fire;
      Err   <= fire & fault;
      if (fire) Dout <= (fault | acc_we) ? 32'd0 : ldata;
    end
  end

endmodule
